// File: rtl/demux8_frame_loader.sv
// -----------------------------------------------------------------------------
// demux8_frame_loader
//
// Byte-wide 1-to-8 distributor. Accepted bytes are steered into one of eight
// registered slots A..H. The block tracks which slots hold data and freezes
// a complete 8-byte frame until the consumer acknowledges it. Sel uses the
// same encoding as the paired 8-to-1 byte mux: {Sel[0],Sel[1],Sel[2]} = 0..7
// selects A..H. Sel is declared [0:2] so that Sel[0] is the MSB.
//
// Optional feature macro: DEMUX8_AUTOINC_EN
//   When defined, Auto=1 steers bytes by an internal 3-bit pointer instead
//   of Sel. The Auto choice is captured on the first accept of a frame and
//   held until the block returns to IDLE.
//   When undefined, Auto is ignored and no pointer logic exists.
//
// Ports:
//   Clk      in   rising-edge clock
//   Rst_n    in   asynchronous active-low reset
//   Din      in   WIDTH-bit byte to load
//   Sel      in   [0:2] target slot, Sel[0] is the MSB
//   Valid    in   Din/Sel valid this cycle
//   Ready    out  block can accept a byte (decoded from state)
//   Auto     in   use internal pointer instead of Sel (feature builds only)
//   Ack      in   consumer has taken the full frame
//   Clear    in   synchronous clear of all registers and state
//   A..H     out  WIDTH-bit slot registers
//   Written  out  slot-written mask, bit i = slot i (A = bit 0)
//   Done     out  one-cycle pulse in the first cycle of HOLD
// -----------------------------------------------------------------------------
module demux8_frame_loader #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [WIDTH-1:0] Din,
  input  logic [0:2]       Sel,
  input  logic             Valid,
  output logic             Ready,
  input  logic             Auto,
  input  logic             Ack,
  input  logic             Clear,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] E,
  output logic [WIDTH-1:0] F,
  output logic [WIDTH-1:0] G,
  output logic [WIDTH-1:0] H,
  output logic [7:0]       Written,
  output logic             Done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_slot [8];
  logic [7:0]       r_written;
  logic             r_done;

  logic [2:0]       w_idx;
  logic [7:0]       w_onehot;
  logic [7:0]       w_written_next;
  logic             w_accept;

`ifdef DEMUX8_AUTOINC_EN
  logic [2:0]       r_ptr;
  logic             r_auto_lat;
  logic             w_use_auto;

  // Auto is live only in IDLE; inside a frame the latched choice is used.
  assign w_use_auto = (r_state == S_IDLE) ? Auto : r_auto_lat;
`else
  logic             w_unused;

  // Auto has no function in this build.
  assign w_unused = &{1'b0, Auto};
`endif

  // Ready is decoded straight from state so it drops in the first HOLD cycle.
  assign Ready    = (r_state != S_HOLD);
  assign w_accept = Valid & Ready;

  // Slot index selection and next written mask.
  always_comb begin
    w_idx = {Sel[0], Sel[1], Sel[2]};
`ifdef DEMUX8_AUTOINC_EN
    if (w_use_auto) begin
      w_idx = r_ptr;
    end else begin
      w_idx = {Sel[0], Sel[1], Sel[2]};
    end
`endif
    w_onehot       = 8'd1 << w_idx;
    w_written_next = r_written | w_onehot;
  end

  // Frame FSM with slot registers, written mask and Done pulse.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state   <= S_IDLE;
      r_written <= 8'd0;
      r_done    <= 1'b0;
      for (int i = 0; i < 8; i++) r_slot[i] <= '0;
`ifdef DEMUX8_AUTOINC_EN
      r_ptr      <= 3'd0;
      r_auto_lat <= 1'b0;
`endif
    end else if (Clear) begin
      r_state   <= S_IDLE;
      r_written <= 8'd0;
      r_done    <= 1'b0;
      for (int i = 0; i < 8; i++) r_slot[i] <= '0;
`ifdef DEMUX8_AUTOINC_EN
      r_ptr      <= 3'd0;
      r_auto_lat <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_FILL: begin
          if (w_accept) begin
            r_slot[w_idx] <= Din;
            r_written     <= w_written_next;
`ifdef DEMUX8_AUTOINC_EN
            r_ptr <= r_ptr + 3'd1;
            if (r_state == S_IDLE) begin
              r_auto_lat <= Auto;
            end else begin
              r_auto_lat <= r_auto_lat;
            end
`endif
            // Overwrites leave the mask unchanged, so only a truly new
            // slot can complete the frame.
            if (w_written_next == 8'hFF) begin
              r_state <= S_HOLD;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_FILL;
            end
          end else begin
            r_state <= r_state;
          end
        end
        S_HOLD: begin
          // Ack releases the mask only; slot data stays for the consumer.
          if (Ack) begin
            r_state   <= S_IDLE;
            r_written <= 8'd0;
`ifdef DEMUX8_AUTOINC_EN
            r_ptr <= 3'd0;
`endif
          end else begin
            r_state <= S_HOLD;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_written <= 8'd0;
        end
      endcase
    end
  end

  assign A       = r_slot[0];
  assign B       = r_slot[1];
  assign C       = r_slot[2];
  assign D       = r_slot[3];
  assign E       = r_slot[4];
  assign F       = r_slot[5];
  assign G       = r_slot[6];
  assign H       = r_slot[7];
  assign Written = r_written;
  assign Done    = r_done;

endmodule

// File: tb/tb_demux8_frame_loader.sv
// -----------------------------------------------------------------------------
// tb_demux8_frame_loader
//
// Directed self-checking bench for demux8_frame_loader. Inputs change 1 time
// unit after a rising edge; outputs are sampled at that same point, well away
// from the next active edge. Feature macro DEMUX8_AUTOINC_EN selects which
// Auto-mode expectations apply.
// -----------------------------------------------------------------------------
module tb_demux8_frame_loader;

  logic       Clk;
  logic       Rst_n;
  logic [7:0] Din;
  logic [0:2] Sel;
  logic       Valid;
  logic       Ready;
  logic       Auto;
  logic       Ack;
  logic       Clear;
  logic [7:0] A, B, C, D, E, F, G, H;
  logic [7:0] Written;
  logic       Done;

  int n_checks = 0;
  int n_errors = 0;

  demux8_frame_loader #(.WIDTH(8)) u_dut (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .Din     (Din),
    .Sel     (Sel),
    .Valid   (Valid),
    .Ready   (Ready),
    .Auto    (Auto),
    .Ack     (Ack),
    .Clear   (Clear),
    .A       (A),
    .B       (B),
    .C       (C),
    .D       (D),
    .E       (E),
    .F       (F),
    .G       (G),
    .H       (H),
    .Written (Written),
    .Done    (Done)
  );

  // 10-unit clock.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] slot_val(input int idx);
    case (idx)
      0:       return A;
      1:       return B;
      2:       return C;
      3:       return D;
      4:       return E;
      5:       return F;
      6:       return G;
      7:       return H;
      default: return 8'hXX;
    endcase
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic put(input logic [2:0] s, input logic [7:0] d);
    Sel   = s;
    Din   = d;
    Valid = 1'b1;
    step();
    Valid = 1'b0;
  endtask

  task automatic do_clear();
    Clear = 1'b1;
    step();
    Clear = 1'b0;
  endtask

  initial begin
    Rst_n = 1'b0;
    Din   = 8'h00;
    Sel   = 3'b000;
    Valid = 1'b0;
    Auto  = 1'b0;
    Ack   = 1'b0;
    Clear = 1'b0;
    #12;
    check_val("rst_written", Written, 8'h00);
    check_val("rst_a", A, 8'h00);
    check_val("rst_done", Done, 1'b0);
    check_val("rst_ready", Ready, 1'b1);
    step();
    Rst_n = 1'b1;
    step();

    // Sel mapping: Sel[0] is the MSB.
    put(3'b001, 8'hB1);
    check_val("sel001_b", B, 8'hB1);
    check_val("sel001_written", Written, 8'h02);
    check_val("sel001_a_untouched", A, 8'h00);
    put(3'b100, 8'hE5);
    check_val("sel100_e", E, 8'hE5);
    check_val("sel100_written", Written, 8'h12);
    check_val("fill_ready", Ready, 1'b1);
    check_val("fill_done", Done, 1'b0);

    // Clear beats Valid in the same cycle.
    Sel   = 3'b000;
    Din   = 8'hFF;
    Valid = 1'b1;
    Clear = 1'b1;
    step();
    Valid = 1'b0;
    Clear = 1'b0;
    check_val("clr_a", A, 8'h00);
    check_val("clr_b", B, 8'h00);
    check_val("clr_e", E, 8'h00);
    check_val("clr_written", Written, 8'h00);
    check_val("clr_ready", Ready, 1'b1);

    // Overwrite of an already-written slot.
    put(3'b000, 8'h01);
    put(3'b000, 8'h02);
    check_val("ovw_a", A, 8'h02);
    check_val("ovw_written", Written, 8'h01);
    check_val("ovw_ready", Ready, 1'b1);
    check_val("ovw_done", Done, 1'b0);
    do_clear();

    // Full frame A..H = 10..17.
    for (int i = 0; i < 8; i++) begin
      put(i[2:0], 8'h10 + i[7:0]);
      if (i < 7) check_val($sformatf("frame_nodone_%0d", i), Done, 1'b0);
    end
    check_val("frame_done", Done, 1'b1);
    check_val("frame_ready", Ready, 1'b0);
    check_val("frame_written", Written, 8'hFF);
    step();
    check_val("hold_done_drop", Done, 1'b0);
    check_val("hold_ready", Ready, 1'b0);
    for (int i = 0; i < 8; i++)
      check_val($sformatf("frame_slot_%0d", i), slot_val(i), 8'h10 + i[7:0]);

    // Valid with Ack in HOLD: byte refused, Ack taken.
    Sel   = 3'b000;
    Din   = 8'h55;
    Valid = 1'b1;
    Ack   = 1'b1;
    step();
    Valid = 1'b0;
    Ack   = 1'b0;
    check_val("ack_ready", Ready, 1'b1);
    check_val("ack_written", Written, 8'h00);
    check_val("ack_a_kept", A, 8'h10);
    check_val("ack_h_kept", H, 8'h17);
    check_val("ack_done", Done, 1'b0);
    put(3'b010, 8'h77);
    check_val("post_ack_c", C, 8'h77);
    check_val("post_ack_written", Written, 8'h04);
    check_val("post_ack_a", A, 8'h10);
    do_clear();

`ifdef DEMUX8_AUTOINC_EN
    // Auto mode: Sel pinned at 111, pointer walks A..H.
    Auto = 1'b1;
    for (int i = 0; i < 8; i++) put(3'b111, 8'hA0 + i[7:0]);
    check_val("auto_done", Done, 1'b1);
    for (int i = 0; i < 8; i++)
      check_val($sformatf("auto_slot_%0d", i), slot_val(i), 8'hA0 + i[7:0]);
    Ack = 1'b1;
    step();
    Ack = 1'b0;
    put(3'b111, 8'hC3);
    check_val("auto_after_ack_a", A, 8'hC3);
    check_val("auto_after_ack_written", Written, 8'h01);
    check_val("auto_after_ack_h", H, 8'hA7);
    Auto = 1'b0;
`else
    // Auto has no effect in this build: Sel still decides.
    Auto = 1'b1;
    put(3'b111, 8'h5A);
    check_val("noauto_h", H, 8'h5A);
    check_val("noauto_written", Written, 8'h80);
    check_val("noauto_a", A, 8'h00);
    Auto = 1'b0;
`endif
    do_clear();

    // Asynchronous reset mid-frame.
    put(3'b000, 8'h11);
    put(3'b001, 8'h22);
    put(3'b010, 8'h33);
    put(3'b011, 8'h44);
    check_val("pre_rst_written", Written, 8'h0F);
    check_val("pre_rst_a", A, 8'h11);
    #2;
    Rst_n = 1'b0;
    #1;
    check_val("arst_a", A, 8'h00);
    check_val("arst_d", D, 8'h00);
    check_val("arst_written", Written, 8'h00);
    check_val("arst_done", Done, 1'b0);
    check_val("arst_ready", Ready, 1'b1);
    step();
    Rst_n = 1'b1;
    step();
    check_val("post_rst_done", Done, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/demux8_frame_loader.md
# demux8_frame_loader

- Byte-wide 1-to-8 distributor with registered outputs: loads incoming bytes into eight output registers A–H.
- Each byte is steered by a 3-bit select, or optionally by an internal auto-incrementing pointer.
- Tracks which slots have been written and holds a complete 8-byte frame until the consumer acknowledges it.
- Sits upstream of the 8-to-1 byte mux in the datapath, using the same Sel encoding and slot names so the two blocks pair directly.

## Interface
Parameters:
- WIDTH, 8, data width of Din and of each output register

Ports:
- Clk  in  1  rising-edge clock
- Rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- Din  in  WIDTH  byte to load
- Sel  in  3  target slot; Sel[0] is the MSB: {Sel[0],Sel[1],Sel[2]} = 0..7 selects A..H
- Valid  in  1  Din/Sel valid this cycle
- Ready  out  1  block can accept a byte (combinational from state)
- Auto  in  1  1 = use internal pointer instead of Sel (only with DEMUX8_AUTOINC_EN)
- Ack  in  1  consumer has taken the full frame
- Clear  in  1  synchronous clear of all registers and state
- A,B,C,D,E,F,G,H  out  WIDTH each  slot registers
- Written  out  8  slot-written mask, bit i = slot i (A = bit 0)
- Done  out  1  one-cycle pulse on frame completion

## Operation
- **Accept rule:** a byte is accepted on a rising Clk edge with Valid=1 and Ready=1.
  - The target slot register takes Din.
  - The matching Written bit is set.
- **States:**
  - IDLE: Written=0, Ready=1.
  - FILL: Written nonzero and not full, Ready=1.
  - HOLD: Written=8'hFF, Ready=0.
- **Transitions:**
  - IDLE→FILL on the first accept.
  - FILL→HOLD on the accept that makes Written=8'hFF.
  - HOLD→IDLE on Ack=1.
  - Any state→IDLE on Clear=1.
- **Overwrite:** writing an already-written slot in FILL replaces the data; Written is unchanged and no progress is made toward HOLD.
- **Ack behaviour:**
  - In HOLD: clears Written only. A–H keep their values for the consumer.
  - In IDLE or FILL: ignored.
- **Clear:**
  - Highest priority; overrides Valid and Ack in the same cycle.
  - Zeroes A–H, Written, Done and the pointer.
  - State goes to IDLE.
- **Done:** registered; pulses exactly once per frame, in the first cycle of HOLD.
- **Width rule:** Din is stored unmodified; no truncation or extension inside the block.

## Timing
- **Reset values (Rst_n=0, asynchronous):**
  - A–H = 0, Written = 0, Done = 0, pointer = 0, state = IDLE.
  - Ready = 1 (follows the IDLE state).
- **Write latency:** a byte accepted at edge N is visible on its slot output and on Written after edge N.
- **Done timing:** Done is high for the single cycle after the completing edge; Ready is 0 from that same cycle.
- **HOLD release:** Ack sampled at edge N in HOLD gives Ready=1 and Written=0 after edge N. The earliest next accept is at edge N+1.
- **Valid and Ack together in HOLD:** Valid is not accepted (Ready=0) and Ack is taken. The byte must be re-presented.
- **Reset mid-frame:** partial contents and the mask are discarded immediately; no Done is generated.
- **Throughput:** one byte per cycle in IDLE/FILL. A full frame costs 8 accepts plus at least one HOLD cycle.

## Configuration
- **DEMUX8_AUTOINC_EN defined:**
  - With Auto=1, Sel is ignored and the slot is taken from a 3-bit pointer.
  - The pointer increments on each accept and wraps 7→0.
  - The pointer resets to 0 on Rst_n, Clear, and on leaving HOLD via Ack.
  - Auto may change only in IDLE; a change in FILL is ignored until the next IDLE.
- **DEMUX8_AUTOINC_EN not defined:**
  - Auto is ignored and no pointer logic is built.
  - Sel always selects the slot.

## Test plan
- **Reset:** Rst_n low mid-FILL (Written=8'h0F, A=8'h11) → immediately A–H=0, Written=0, Done=0, Ready=1.
- **Sel mapping:**
  - Inputs: Sel=3'b001, Din=8'hB1, Valid=1.
  - Expected: B=8'hB1 and Written=8'h02 after the edge.
  - Also check: Sel=3'b100 with Din=8'hE5 → E=8'hE5, Written bit 4 set.
- **Full frame:**
  - Inputs: eight accepts to Sel 0..7 (MSB-first encoding) with Din=8'h10..8'h17.
  - Expected: Done pulses one cycle, Ready=0, Written=8'hFF, slot values are correct.
  - Then Valid=1 with Ack=1 → byte not accepted, Ready=1 next cycle, A–H unchanged.
- **Overwrite:**
  - Inputs: write A=8'h01 then A=8'h02.
  - Expected: A=8'h02, Written=8'h01, state remains FILL, no Done.
- **Clear priority:** Clear=1 together with Valid=1 (Din=8'hFF) in FILL → all outputs 0 and the byte is dropped.
- **Auto mode (DEMUX8_AUTOINC_EN, Auto=1):**
  - Inputs: Sel held at 3'b111, eight bytes 8'hA0..8'hA7.
  - Expected: A..H = 8'hA0..8'hA7 and Done pulses.
  - After Ack, the next byte lands in A.
